// File: rtl/fusion_pkg.sv
// Shared types for the quarter-unit fused multiplier path and its accumulator stage.
package fusion_pkg;

  localparam int QU_DATA_W    = 16;
  localparam int QU_LANES_MAX = 4;

  typedef enum logic [1:0] {FUSE_4L, FUSE_2L, FUSE_1L, FUSE_RSVD} fuse_mode_t;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} acc_state_t;

  function automatic logic [QU_LANES_MAX-1:0] lane_mask(input fuse_mode_t m);
    case (m)
      FUSE_4L: lane_mask = 4'b1111;
      FUSE_2L: lane_mask = 4'b0011;
      FUSE_1L: lane_mask = 4'b0001;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lane_unpack.sv
// Splits one packed product word into up to four lanes, each sign- or zero-extended
// (or truncated) to the accumulator width.
module lane_unpack
  import fusion_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [QU_DATA_W-1:0]              data,
  input  fuse_mode_t                        mode,
  input  logic                              sgn,
  output logic [QU_LANES_MAX-1:0][ACC_W-1:0] lanes,
  output logic [QU_LANES_MAX-1:0]           mask
);

  logic [QU_LANES_MAX-1:0][15:0] l16;

  function automatic logic [ACC_W-1:0] ext16(input logic [15:0] v, input logic s);
    return ACC_W'({{ACC_W{s & v[15]}}, v});
  endfunction

  always_comb begin
    l16  = '0;
    mask = lane_mask(mode);
    case (mode)
      FUSE_4L: for (int i = 0; i < 4; i++) l16[i] = {{12{sgn & data[4*i+3]}}, data[4*i +: 4]};
      FUSE_2L: for (int j = 0; j < 2; j++) l16[j] = {{8{sgn & data[8*j+7]}}, data[8*j +: 8]};
      FUSE_1L: l16[0] = data;
      default: l16 = '0;
    endcase
    // Lanes are already 16-bit extended, so the final step only widens or truncates.
    for (int i = 0; i < QU_LANES_MAX; i++) lanes[i] = ext16(l16[i], sgn);
  end

endmodule

// File: rtl/fused_accumulator.sv
// Per-lane dot-product accumulator behind the quarter-unit fused multiplier.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
module fused_accumulator
  import fusion_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [QU_DATA_W-1:0] in_data,
  input  logic [1:0]           in_mode,
  input  logic                 in_signed,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*ACC_W-1:0]   out_acc,
  output logic [1:0]           out_mode,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf,
  output acc_state_t           dbg_state
);

  acc_state_t state, state_nxt;
  fuse_mode_t mode_q, use_mode;
  logic       signed_q, use_signed, beat, take, ovf;
  logic [QU_LANES_MAX-1:0][ACC_W-1:0] acc, acc_nxt, lanes;
  logic [QU_LANES_MAX-1:0]            mask, lane_ovf;
  logic [ACC_W:0]                     wide [QU_LANES_MAX];
  logic [CNT_W-1:0]                   count;

  // The first beat of a group uses the live mode/sign; later beats use the latched copy.
  assign use_mode   = (state == S_IDLE) ? fuse_mode_t'(in_mode) : mode_q;
  assign use_signed = (state == S_IDLE) ? in_signed : signed_q;
  assign beat       = in_valid && in_ready;
  assign take       = beat && ((state != S_IDLE) || (use_mode != FUSE_RSVD));

  lane_unpack #(.ACC_W(ACC_W)) u_unpack (
    .data  (in_data),
    .mode  (use_mode),
    .sgn   (use_signed),
    .lanes (lanes),
    .mask  (mask)
  );

  always_comb begin
    acc_nxt  = acc;
    lane_ovf = '0;
    for (int i = 0; i < QU_LANES_MAX; i++) begin
      wide[i] = {1'b0, acc[i]} + {1'b0, lanes[i]};
      if (mask[i]) begin
        acc_nxt[i]  = wide[i][ACC_W-1:0];
        lane_ovf[i] = use_signed
          ? ((acc[i][ACC_W-1] == lanes[i][ACC_W-1]) && (wide[i][ACC_W-1] != acc[i][ACC_W-1]))
          : wide[i][ACC_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take) state_nxt = in_last ? S_HOLD : S_ACCUM;
      S_ACCUM: if (take && in_last) state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      mode_q   <= FUSE_4L;
      signed_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_HOLD && out_ready) begin
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end else if (take) begin
        acc <= acc_nxt;
        ovf <= ovf | (|lane_ovf);
        // Count saturates at all-ones instead of wrapping.
        if (state == S_IDLE) count <= CNT_W'(1);
        else if (!(&count)) count <= count + CNT_W'(1);
        if (state == S_IDLE) begin
          mode_q   <= use_mode;
          signed_q <= in_signed;
        end
      end
    end
  end

  assign in_ready  = (state != S_HOLD);
  assign out_valid = (state == S_HOLD);
  assign out_acc   = acc;
  assign out_mode  = mode_q;
  assign out_count = count;
  assign out_ovf   = ovf;
  assign dbg_state = state;

endmodule

// File: tb/tb_fused_accumulator.sv
// Bench for fused_accumulator: two widths (24 and 8) driven in lockstep, checked against an
// arithmetic model each cycle plus hand-computed expectations.
module tb_fused_accumulator;
  import fusion_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_signed, in_last, out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;

  logic        in_ready, out_valid, out_ovf;
  logic [95:0] out_acc;
  logic [1:0]  out_mode;
  logic [15:0] out_count;
  acc_state_t  dbg_state;

  logic        in_ready8, out_valid8, out_ovf8;
  logic [31:0] out_acc8;
  logic [1:0]  out_mode8;
  logic [15:0] out_count8;
  acc_state_t  dbg_state8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [95:0] acc24;
    logic [31:0] acc8;
    logic [1:0]  mode;
    logic [15:0] count;
    logic        ovf24;
    logic        ovf8;
  } exp_t;
  exp_t exp_q[$];

  fused_accumulator #(.ACC_W(24), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_signed(in_signed), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_mode(out_mode), .out_count(out_count),
    .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  fused_accumulator #(.ACC_W(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .in_mode(in_mode), .in_signed(in_signed), .in_last(in_last), .out_valid(out_valid8),
    .out_ready(out_ready), .out_acc(out_acc8), .out_mode(out_mode8), .out_count(out_count8),
    .out_ovf(out_ovf8), .dbg_state(dbg_state8)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_acc24 [4];
  longint m_acc8  [4];
  bit     m_ovf24, m_ovf8, m_sgn, m_busy, m_hold;
  int     m_count;
  logic [1:0] m_mode;

  function automatic longint wrapw(input longint x, input int w);
    longint m;
    m = longint'(1) << w;
    return ((x % m) + m) % m;
  endfunction

  function automatic longint as_signed(input longint u, input int w);
    return (u >= (longint'(1) << (w - 1))) ? u - (longint'(1) << w) : u;
  endfunction

  task automatic accum(inout longint acc, inout bit ovf, input longint f, input int w);
    longint a, b, s;
    if (m_sgn) begin
      a = as_signed(acc, w);
      b = as_signed(wrapw(f, w), w);
      s = a + b;
      if (s > (longint'(1) << (w - 1)) - 1 || s < -(longint'(1) << (w - 1))) ovf = 1'b1;
    end else begin
      a = acc;
      b = wrapw(f, w);
      s = a + b;
      if (s >= (longint'(1) << w)) ovf = 1'b1;
    end
    acc = wrapw(s, w);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_acc24[i] = 0;
      m_acc8[i]  = 0;
    end
    m_ovf24 = 0; m_ovf8 = 0; m_count = 0;
  endtask

  task automatic model_beat(input logic [15:0] d);
    int nl, fw;
    longint f;
    nl = (m_mode == 2'b00) ? 4 : (m_mode == 2'b01) ? 2 : 1;
    fw = 16 / nl;
    for (int i = 0; i < nl; i++) begin
      f = (longint'(d) >> (fw * i)) & ((longint'(1) << fw) - 1);
      if (m_sgn && f >= (longint'(1) << (fw - 1))) f = f - (longint'(1) << fw);
      accum(m_acc24[i], m_ovf24, f, 24);
      accum(m_acc8[i], m_ovf8, f, 8);
    end
    m_count = (m_count < 65535) ? m_count + 1 : 65535;
  endtask

  task automatic model_push();
    exp_t e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e.acc24[24*i +: 24] = m_acc24[i][23:0];
      e.acc8[8*i +: 8]    = m_acc8[i][7:0];
    end
    e.mode  = m_mode;
    e.count = m_count[15:0];
    e.ovf24 = m_ovf24;
    e.ovf8  = m_ovf8;
    exp_q.push_back(e);
  endtask

  initial begin
    m_hold = 0; m_busy = 0; m_mode = 0; m_sgn = 0;
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_hold = 0; m_busy = 0; m_mode = 0; m_sgn = 0;
        model_clear();
        exp_q.delete();
      end else if (m_hold) begin
        if (out_ready) begin
          m_hold = 0;
          void'(exp_q.pop_front());
        end
      end else if (in_valid) begin
        if (!m_busy && in_mode != 2'b11) begin
          m_busy = 1; m_mode = in_mode; m_sgn = in_signed;
          model_clear();
        end
        if (m_busy) begin
          model_beat(in_data);
          if (in_last) begin
            model_push();
            m_busy = 0; m_hold = 1;
            model_clear();
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("out_valid", 128'(out_valid), 128'(m_hold));
        check("in_ready", 128'(in_ready), 128'(!m_hold));
        check("out_valid8", 128'(out_valid8), 128'(m_hold));
        check("in_ready8", 128'(in_ready8), 128'(!m_hold));
        if (m_hold) begin
          if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 128'(0), 128'(1));
          end else begin
            e = exp_q[0];
            check("out_acc", 128'(out_acc), 128'(e.acc24));
            check("out_acc8", 128'(out_acc8), 128'(e.acc8));
            check("out_mode", 128'(out_mode), 128'(e.mode));
            check("out_count", 128'(out_count), 128'(e.count));
            check("out_count8", 128'(out_count8), 128'(e.count));
            check("out_ovf", 128'(out_ovf), 128'(e.ovf24));
            check("out_ovf8", 128'(out_ovf8), 128'(e.ovf8));
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_beat(input logic [15:0] d, input logic [1:0] m, input logic s, input logic l);
    int n;
    in_valid = 1'b1; in_data = d; in_mode = m; in_signed = s; in_last = l;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_beat_timeout", 128'(0), 128'(1));
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; in_signed = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_acc", 128'(out_acc), 128'(0));
    check("rst_out_mode", 128'(out_mode), 128'(0));
    check("rst_out_count", 128'(out_count), 128'(0));
    check("rst_out_ovf", 128'(out_ovf), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(S_IDLE));
    check("rst_state8", 128'(dbg_state8), 128'(S_IDLE));

    // Reset in the middle of a group.
    send_beat(16'h1111, 2'b00, 1'b0, 1'b0);
    send_beat(16'h2222, 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_count", 128'(out_count), 128'(0));
    check("midrst_out_acc", 128'(out_acc), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Mode 00 unsigned, three beats of 4321.
    send_beat(16'h4321, 2'b00, 1'b0, 1'b0);
    send_beat(16'h4321, 2'b00, 1'b0, 1'b0);
    send_beat(16'h4321, 2'b00, 1'b0, 1'b1);
    check("m00_valid", 128'(out_valid), 128'(1));
    check("m00_acc", 128'(out_acc), 128'({24'd12, 24'd9, 24'd6, 24'd3}));
    check("m00_count", 128'(out_count), 128'(3));
    check("m00_ovf", 128'(out_ovf), 128'(0));

    // Mode 01 signed.
    send_beat(16'hFF02, 2'b01, 1'b1, 1'b0);
    send_beat(16'h0180, 2'b01, 1'b1, 1'b1);
    check("m01_acc", 128'(out_acc), 128'({48'd0, 24'd0, 24'hFFFF82}));
    check("m01_acc8", 128'(out_acc8), 128'(32'h0000_0082));
    check("m01_mode", 128'(out_mode), 128'(2'b01));
    check("m01_ovf", 128'(out_ovf), 128'(0));

    // Mode 10 signed single beat.
    send_beat(16'h8000, 2'b10, 1'b1, 1'b1);
    check("m10_valid", 128'(out_valid), 128'(1));
    check("m10_acc", 128'(out_acc), 128'({72'd0, 24'hFF8000}));
    check("m10_count", 128'(out_count), 128'(1));

    // Reserved mode on a first beat is swallowed.
    send_beat(16'h1111, 2'b11, 1'b0, 1'b1);
    check("rsvd_no_result", 128'(out_valid), 128'(0));
    check("rsvd_in_ready", 128'(in_ready), 128'(1));

    // Backpressure in HOLD with the next beat waiting.
    out_ready = 1'b0;
    send_beat(16'h1234, 2'b00, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 16'h0005; in_mode = 2'b10; in_signed = 1'b0; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_acc", 128'(out_acc), 128'({24'd1, 24'd2, 24'd3, 24'd4}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_bubble_valid", 128'(out_valid), 128'(0));
    check("bp_bubble_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_next_valid", 128'(out_valid), 128'(1));
    check("bp_next_acc", 128'(out_acc), 128'({72'd0, 24'd5}));
    check("bp_next_count", 128'(out_count), 128'(1));

    // Narrow accumulator overflow; mode change mid-group is ignored.
    send_beat(16'h00F0, 2'b10, 1'b0, 1'b0);
    send_beat(16'h00F0, 2'b00, 1'b0, 1'b1);
    check("ovf8_acc", 128'(out_acc8), 128'(32'h0000_00E0));
    check("ovf8_flag", 128'(out_ovf8), 128'(1));
    check("ovf8_mode", 128'(out_mode8), 128'(2'b10));
    check("ovf24_acc", 128'(out_acc), 128'({72'd0, 24'h0001E0}));
    check("ovf24_flag", 128'(out_ovf), 128'(0));

    // Signed overflow on the narrow instance, mode 01.
    send_beat(16'h7F7F, 2'b01, 1'b1, 1'b0);
    send_beat(16'h0101, 2'b01, 1'b1, 1'b1);
    check("sovf8_acc", 128'(out_acc8), 128'(32'h0000_8080));
    check("sovf8_flag", 128'(out_ovf8), 128'(1));

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
